burrito_ctrl: RTL

Multi-cycle sequencer for the Burrito register-file/ALU datapath. Fetches 32-bit instructions from an external instruction memory over a req/ack handshake, extracts opcode and register fields, and drives the register-file read/write addresses, the ALU opcode and a single-cycle write enable. It registers the ALU result for write-back and stops on a HALT opcode. It sits between instruction memory and the brr/ALU pair, and replaces the datapath's hard-wired `we=1` with a controlled write strobe.

---
 rtl/burrito_pkg.sv | 29 ++
 rtl/burrito_if.sv | 19 +
 rtl/burrito_fetch.sv | 36 +++
 rtl/burrito_ctrl.sv | 78 +++++++
 4 files changed

// File: rtl/burrito_pkg.sv
// Shared types and constants for the Burrito sequencer: instruction field
// layout, default HALT opcode and the controller state encoding.
package burrito_pkg;
  localparam int OP_W    = 5;
  localparam int RA_W    = 5;
  localparam int INSTR_W = 32;

  localparam int OP_LSB  = 27;
  localparam int OP1_LSB = 22;
  localparam int OP2_LSB = 17;
  localparam int RD_LSB  = 12;
  // Only the decoded fields are kept; the low 12 bits carry nothing.
  localparam int IR_W    = INSTR_W - RD_LSB;

  localparam logic [OP_W-1:0] HALT_OP_DEF = 5'h1F;

  typedef enum logic [2:0] {IDLE, FETCH, DECODE, EXEC, WB, HALT} state_t;

  typedef struct packed {
    logic [OP_W-1:0] op;
    logic [RA_W-1:0] op1;
    logic [RA_W-1:0] op2;
    logic [RA_W-1:0] rd;
  } fields_t;

  function automatic fields_t decode(input logic [IR_W-1:0] ir);
    return fields_t'(ir);
  endfunction
endpackage

// File: rtl/burrito_if.sv
// Instruction-memory handshake plus register-file/ALU drive bundle.
interface burrito_if #(parameter int PC_W = 8);
  logic                          imem_req;
  logic [PC_W-1:0]               imem_addr;
  logic                          imem_ack;
  logic [burrito_pkg::INSTR_W-1:0] imem_data;
  logic [burrito_pkg::RA_W-1:0]  rf_ar1, rf_ar2, rf_aw;
  logic                          rf_we;
  logic [burrito_pkg::OP_W-1:0]  alu_op;
  logic [31:0]                   alu_c;
  logic [31:0]                   wb_data;

  modport master (output imem_req, imem_addr, rf_ar1, rf_ar2, rf_aw, rf_we,
                         alu_op, wb_data,
                  input  imem_ack, imem_data, alu_c);
  modport slave  (input  imem_req, imem_addr, rf_ar1, rf_ar2, rf_aw, rf_we,
                         alu_op, wb_data,
                  output imem_ack, imem_data, alu_c);
endinterface

// File: rtl/burrito_fetch.sv
// Program counter, req/ack fetch handshake and instruction register.
module burrito_fetch
  import burrito_pkg::*;
#(
  parameter int PC_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load_pc0,
  input  logic               advance,
  input  logic               fetch_go,
  input  logic               ack,
  input  logic [INSTR_W-1:0] data,
  output logic               req,
  output logic [PC_W-1:0]    pc,
  output logic [IR_W-1:0]    ir,
  output logic               instr_valid
);
  logic unused_lo;
  assign unused_lo = ^data[RD_LSB-1:0];

  // req follows the FETCH state directly so an async reset drops it at once.
  assign req         = fetch_go;
  assign instr_valid = fetch_go && ack;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc <= '0;
      ir <= '0;
    end else begin
      if (load_pc0)     pc <= '0;
      else if (advance) pc <= pc + 1'b1;
      if (instr_valid)  ir <= data[INSTR_W-1:RD_LSB];
    end
  end
endmodule

// File: rtl/burrito_ctrl.sv
// Burrito sequencer: FETCH/DECODE/EXEC/WB control, result register and
// retired-instruction counter around the fetch unit.
module burrito_ctrl
  import burrito_pkg::*;
#(
  parameter int              PC_W    = 8,
  parameter logic [OP_W-1:0] HALT_OP = HALT_OP_DEF,
  parameter int              RET_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  burrito_if.master        bus,
  output logic             busy,
  output logic             halted,
  output logic [RET_W-1:0] retired
);
  state_t          state, nxt;
  logic [IR_W-1:0] ir;
  fields_t         f;
  logic            instr_valid, launch;

  assign launch = start && (state == IDLE || state == HALT);

  burrito_fetch #(.PC_W(PC_W)) u_fetch (
    .clk         (clk),
    .rst         (rst),
    .load_pc0    (launch),
    .advance     (state == WB),
    .fetch_go    (state == FETCH),
    .ack         (bus.imem_ack),
    .data        (bus.imem_data),
    .req         (bus.imem_req),
    .pc          (bus.imem_addr),
    .ir          (ir),
    .instr_valid (instr_valid)
  );

  // Field drives come straight from the IR, which only changes on a fetch ack,
  // so they hold their last values outside DECODE/EXEC/WB.
  assign f          = decode(ir);
  assign bus.rf_ar1 = f.op1;
  assign bus.rf_ar2 = f.op2;
  assign bus.rf_aw  = f.rd;
  assign bus.alu_op = f.op;
  assign bus.rf_we  = (state == WB);
  assign busy       = (state == FETCH) || (state == DECODE) ||
                      (state == EXEC)  || (state == WB);
  assign halted     = (state == HALT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= nxt;
  end

  always_comb begin
    nxt = state;
    case (state)
      IDLE, HALT: if (start) nxt = FETCH;
      FETCH:      if (instr_valid) nxt = DECODE;
      DECODE:     nxt = (f.op == HALT_OP) ? HALT : EXEC;
      EXEC:       nxt = WB;
      WB:         nxt = FETCH;
      default:    nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.wb_data <= '0;
      retired     <= '0;
    end else begin
      if (state == EXEC) bus.wb_data <= bus.alu_c;
      if (launch)           retired <= '0;
      else if (state == WB) retired <= retired + 1'b1;
    end
  end
endmodule
